// File: rtl/instr_split_queue.sv
// Instruction queue: DEPTH-entry FIFO of {instr, pc} with MIPS field decode of the head entry.
// Optional macro SPLIT_IMM_EXT_EN enables opcode-dependent imm32 extension; otherwise imm32 is 0.
module instr_split_queue #(
    parameter int DEPTH = 2,
    parameter int CNT_W = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [31:0]      instr,
    input  logic [31:0]      pc,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [31:0]      out_pc,
    output logic [5:0]       opcode,
    output logic [4:0]       rs,
    output logic [4:0]       rt,
    output logic [4:0]       rd,
    output logic [4:0]       shamt,
    output logic [5:0]       funct,
    output logic [15:0]      imm16,
    output logic [25:0]      imm26,
    output logic [31:0]      imm32,
    output logic [CNT_W-1:0] count
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [31:0]      instr_mem_q [DEPTH];
    logic [31:0]      pc_mem_q    [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             push, pop;
    logic [31:0]      head_instr;

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
    endfunction

    assign in_ready  = (count_q < CNT_W'(DEPTH));
    assign out_valid = (count_q != '0);
    assign push      = in_valid && in_ready;
    assign pop       = out_valid && out_ready;
    assign count     = count_q;

    // NOTE: every variable gets a default first so this block can never infer a latch.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (push) wr_ptr_d = ptr_inc(wr_ptr_q);
            if (pop)  rd_ptr_d = ptr_inc(rd_ptr_q);
            case ({push, pop})
                2'b10:   count_d = count_q + CNT_W'(1);
                2'b01:   count_d = count_q - CNT_W'(1);
                default: count_d = count_q;
            endcase
        end
    end

    // NOTE: state registers use non-blocking assignments so all of them update together at the edge.
    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // NOTE: storage is deliberately not reset; an empty queue masks its outputs to zero instead.
    always_ff @(posedge clk) begin
        if (push) begin
            instr_mem_q[wr_ptr_q] <= instr;
            pc_mem_q[wr_ptr_q]    <= pc;
        end
    end

    assign head_instr = out_valid ? instr_mem_q[rd_ptr_q] : '0;
    assign out_pc     = out_valid ? pc_mem_q[rd_ptr_q]    : '0;

    assign opcode = head_instr[31:26];
    assign rs     = head_instr[25:21];
    assign rt     = head_instr[20:16];
    assign rd     = head_instr[15:11];
    assign shamt  = head_instr[10:6];
    assign funct  = head_instr[5:0];
    assign imm16  = head_instr[15:0];
    assign imm26  = head_instr[25:0];

`ifdef SPLIT_IMM_EXT_EN
    // lui places imm16 high; logical immediates zero-extend; everything else sign-extends.
    always_comb begin
        case (opcode)
            6'h0F:             imm32 = {imm16, 16'h0000};
            6'h0C, 6'h0D, 6'h0E: imm32 = {16'h0000, imm16};
            default:           imm32 = {{16{imm16[15]}}, imm16};
        endcase
    end
`else
    assign imm32 = '0;
`endif

endmodule

// File: doc/instr_split_queue.md
INSTR_SPLIT_QUEUE -- requirements
Module: instr_split_queue

Interface
REQ-001 Parameter DEPTH, default 2, number of buffered instruction entries; legal values 1..16.
REQ-002 Parameter CNT_W, default $clog2(DEPTH+1), width of the occupancy count.
REQ-003 clk  input  1  single clock; all state updates on its rising edge.
REQ-004 reset  input  1  synchronous, active-high reset.
REQ-005 flush  input  1  synchronous queue clear.
REQ-006 in_valid  input  1  producer presents instr/pc.
REQ-007 in_ready  output  1  queue can accept an entry.
REQ-008 instr  input  32  raw MIPS instruction word.
REQ-009 pc  input  32  address of instr.
REQ-010 out_valid  output  1  head entry is valid.
REQ-011 out_ready  input  1  consumer takes head entry.
REQ-012 out_pc  output  32  pc of head entry.
REQ-013 opcode  output  6  head instr[31:26].
REQ-014 rs  output  5  head instr[25:21].
REQ-015 rt  output  5  head instr[20:16].
REQ-016 rd  output  5  head instr[15:11].
REQ-017 shamt  output  5  head instr[10:6].
REQ-018 funct  output  6  head instr[5:0].
REQ-019 imm16  output  16  head instr[15:0].
REQ-020 imm26  output  26  head instr[25:0].
REQ-021 imm32  output  32  extended immediate of head entry (see Configuration).
REQ-022 count  output  CNT_W  current number of stored entries.

Function
REQ-023 Storage: DEPTH-entry circular FIFO of {instr, pc}; read/write pointers wrap from DEPTH-1 to 0.
REQ-024 in_ready = (count < DEPTH); combinational from registered count only, no dependence on out_ready.
REQ-025 Push when in_valid && in_ready; pop when out_valid && out_ready; out_valid = (count != 0).
REQ-026 Simultaneous push and pop: both occur, count unchanged, pointers both advance.
REQ-027 Full (count == DEPTH): in_ready = 0, in_valid ignored; pop still allowed.
REQ-028 Empty: out_valid = 0; out_ready ignored; all field outputs, out_pc and imm32 driven 0.
REQ-029 Latency: entry pushed at edge N is visible on outputs (out_valid = 1) after edge N when queue was empty; no combinational in-to-out path.
REQ-030 Field outputs are combinational slices of the head entry's registered instr; order is strictly FIFO.
REQ-031 flush = 1 at an edge: count and both pointers go to 0; any push or pop in that cycle is discarded; flush has priority over push/pop.
REQ-032 count increments by 1 on push-only, decrements by 1 on pop-only, never exceeds DEPTH nor underflows.

Reset
REQ-033 reset = 1 at an edge: count = 0, pointers = 0, out_valid = 0, in_ready = 1, all data outputs 0; reset has priority over flush, push and pop.
REQ-034 Storage array contents need not be cleared; outputs are masked to 0 while empty.

Configuration
REQ-035 Macro SPLIT_IMM_EXT_EN defined: imm32 = {imm16,16'h0} for opcode 0x0F (lui); zero-extension of imm16 for opcodes 0x0C, 0x0D, 0x0E (andi, ori, xori); sign-extension of imm16 for all other opcodes.
REQ-036 Macro SPLIT_IMM_EXT_EN undefined: imm32 port remains present and is constant 0; no extension logic is synthesized.

Verification
REQ-037 DEPTH=2, reset, push instr 0x012A4020 pc 0x00003000 -> next cycle out_valid=1, opcode 0, rs 9, rt 10, rd 8, shamt 0, funct 0x20, out_pc 0x00003000, count 1.
REQ-038 SPLIT_IMM_EXT_EN defined, push 0x34088000, 0x8D09FFFC, 0x3C081234 in turn -> imm32 0x00008000, 0xFFFFFFFC, 0x12340000 respectively as each reaches head.
REQ-039 DEPTH=2, out_ready=0, push 3 entries back-to-back -> count 2, in_ready 0 after second push, third entry not stored; then pop both -> pcs emerge in push order, count 0, out_valid 0, outputs 0.
REQ-040 DEPTH=2, count 1, in_valid=1 and out_ready=1 for 6 cycles with pcs 0x3000..0x3014 -> count stays 1, pointers wrap, outputs show pcs in order with one-cycle lag.
REQ-041 count 2, assert flush together with in_valid and out_ready -> next cycle count 0, out_valid 0, in_ready 1, pushed entry absent.
REQ-042 count 2, assert reset together with flush and in_valid -> next cycle count 0, out_valid 0, all data outputs 0.
